inst_sram_axi_rd_bridge: RTL and testbench

- Responder end of the instruction-fetch sram-like interface (req / addr_ok / data_ok / rdata) driven by the fetch stages.
- Accepts fetch requests and issues each as a single-beat AXI4 read.
- Returns read data to the fetch side strictly in request order, one data_ok per accepted request.
- Sits between the fetch pipeline (or icache uncached path) and the AXI read arbiter.

---
 rtl/inst_sram_axi_rd_bridge_pkg.sv | 27 ++
 rtl/inst_sram_axi_rd_bridge.sv | 131 +++++++++++++
 tb/tb_inst_sram_axi_rd_bridge.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/inst_sram_axi_rd_bridge_pkg.sv
// Shared constants for the instruction-fetch sram-like to AXI read bridge.
package inst_sram_axi_rd_bridge_pkg;

    // AXI burst / response encodings used by the bridge
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    // Instruction sram-like bus widths
    localparam int INST_DATA_W = 32;
    localparam int INST_SIZE_W = 2;
    localparam int AXI_ID_W    = 4;
    localparam int AXI_LEN_W   = 8;
    localparam int AXI_SIZE_W  = 3;

    // AXI ID reserved for the instruction fetch port
    localparam int INST_ARID = 0;

    // Outstanding counter width, covers MAX_OUTSTANDING up to 7
    localparam int CNT_W = 3;

    // AR channel states
    typedef enum logic {
        AR_IDLE = 1'b0,
        AR_REQ  = 1'b1
    } ar_state_t;

endpackage

// File: rtl/inst_sram_axi_rd_bridge.sv
// Instruction-fetch sram-like responder that issues each accepted request as a
// single-beat AXI4 read and returns data in request order (single ID).
module inst_sram_axi_rd_bridge
    import inst_sram_axi_rd_bridge_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2,
    parameter int ARID_VAL        = INST_ARID,
    parameter int ADDR_W          = 32
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic                   inst_sram_req_i,
    input  logic [ADDR_W-1:0]      inst_sram_addr_i,
    input  logic [INST_SIZE_W-1:0] inst_sram_size_i,
    output logic                   inst_sram_addr_ok_o,
    output logic                   inst_sram_data_ok_o,
    output logic [INST_DATA_W-1:0] inst_sram_rdata_o,
    output logic                   inst_sram_err_o,

    output logic [AXI_ID_W-1:0]    arid_o,
    output logic [ADDR_W-1:0]      araddr_o,
    output logic [AXI_LEN_W-1:0]   arlen_o,
    output logic [AXI_SIZE_W-1:0]  arsize_o,
    output logic [1:0]             arburst_o,
    output logic                   arvalid_o,
    input  logic                   arready_i,

    input  logic [AXI_ID_W-1:0]    rid_i,
    input  logic [INST_DATA_W-1:0] rdata_i,
    input  logic [1:0]             rresp_i,
    input  logic                   rlast_i,
    input  logic                   rvalid_i,
    output logic                   rready_o
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    ar_state_t        ar_state;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             r_hs;

    // Single ID with in-order return: rid/rlast carry no routing information
    logic unused_r_sideband;
    assign unused_r_sideband = ^{rid_i, rlast_i};

    // Constant AR attributes: one beat, incrementing burst, fixed ID
    assign arid_o    = AXI_ID_W'(ARID_VAL);
    assign arlen_o   = '0;
    assign arburst_o = BURST_INCR;

    // Accept only while no AR is pending and the return budget has room
    assign inst_sram_addr_ok_o = inst_sram_req_i && !arvalid_o && (cnt < MAX_CNT);
    assign accept              = inst_sram_req_i && inst_sram_addr_ok_o;

    // Fetch side never back-pressures, so R is ready whenever a return is owed
    assign rready_o = (cnt != '0);
    assign r_hs     = rvalid_i && rready_o;

    // AR channel FSM: capture request, hold it stable until arready
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ar_state  <= AR_IDLE;
            arvalid_o <= 1'b0;
            araddr_o  <= '0;
            arsize_o  <= '0;
        end else begin
            case (ar_state)
                AR_IDLE: begin
                    if (accept) begin
                        ar_state  <= AR_REQ;
                        arvalid_o <= 1'b1;
                        araddr_o  <= inst_sram_addr_i;
                        arsize_o  <= {1'b0, inst_sram_size_i};
                    end
                end
                AR_REQ: begin
                    if (arready_i) begin
                        ar_state  <= AR_IDLE;
                        arvalid_o <= 1'b0;
                    end
                end
                default: begin
                    ar_state  <= AR_IDLE;
                    arvalid_o <= 1'b0;
                end
            endcase
        end
    end

    // Outstanding counter: +1 on accept, -1 on R handshake, both cancel out
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            case ({accept, r_hs})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Register the R beat and pulse data_ok for exactly one cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst_sram_data_ok_o <= 1'b0;
            inst_sram_rdata_o   <= '0;
            inst_sram_err_o     <= 1'b0;
        end else begin
            inst_sram_data_ok_o <= r_hs;
            if (r_hs) begin
                inst_sram_rdata_o <= rdata_i;
                inst_sram_err_o   <= (rresp_i != RESP_OKAY);
            end
        end
    end

`ifndef SYNTHESIS
    // Protocol checks: no R beat without an owed return, every beat is last
    a_rvalid_without_request: assert property (@(posedge clk) disable iff (rst)
        rvalid_i |-> (cnt != '0))
        else $error("rvalid asserted with no outstanding request");

    a_rlast_single_beat: assert property (@(posedge clk) disable iff (rst)
        r_hs |-> rlast_i)
        else $error("rlast low on a single-beat read");
`endif

endmodule

// File: tb/tb_inst_sram_axi_rd_bridge.sv
// Directed self-checking bench for inst_sram_axi_rd_bridge (MAX_OUTSTANDING=2).
module tb_inst_sram_axi_rd_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata_o;
    logic        err;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata_i;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    int errors = 0;
    int checks = 0;

    inst_sram_axi_rd_bridge #(
        .MAX_OUTSTANDING(2),
        .ARID_VAL(0),
        .ADDR_W(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .inst_sram_req_i(req),
        .inst_sram_addr_i(addr),
        .inst_sram_size_i(size),
        .inst_sram_addr_ok_o(addr_ok),
        .inst_sram_data_ok_o(data_ok),
        .inst_sram_rdata_o(rdata_o),
        .inst_sram_err_o(err),
        .arid_o(arid),
        .araddr_o(araddr),
        .arlen_o(arlen),
        .arsize_o(arsize),
        .arburst_o(arburst),
        .arvalid_o(arvalid),
        .arready_i(arready),
        .rid_i(rid),
        .rdata_i(rdata_i),
        .rresp_i(rresp),
        .rlast_i(rlast),
        .rvalid_i(rvalid),
        .rready_o(rready)
    );

    always #5 clk = ~clk;

    // Advance one clock; registered outputs are settled 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 1'b0; addr = '0; size = 2'b10; arready = 1'b0;
        rid = '0; rdata_i = '0; rresp = 2'b00; rlast = 1'b1; rvalid = 1'b0;
        tick(); tick();
        rst = 1'b0;
        #1;
        checks++; if (arvalid !== 1'b0) begin errors++; $display("FAIL reset_arvalid got=%b want=0", arvalid); end
        checks++; if (araddr !== 32'h0) begin errors++; $display("FAIL reset_araddr got=%h want=00000000", araddr); end
        checks++; if (arsize !== 3'b000) begin errors++; $display("FAIL reset_arsize got=%b want=000", arsize); end
        checks++; if (data_ok !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL reset_dataok_err got=%b%b want=00", data_ok, err); end
        checks++; if (rdata_o !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h want=00000000", rdata_o); end
        checks++; if (rready !== 1'b0 || dut.cnt !== 3'd0) begin errors++; $display("FAIL reset_rready_cnt got=%b/%0d want=0/0", rready, dut.cnt); end
        checks++; if (arid !== 4'd0 || arlen !== 8'd0 || arburst !== 2'b01) begin errors++; $display("FAIL const_ar got id=%h len=%h burst=%b want 0/00/01", arid, arlen, arburst); end
    endtask

    task automatic test_single_fetch();
        tick();
        req = 1'b1; addr = 32'h1C00_0000; size = 2'b10; arready = 1'b1;
        #1;
        checks++; if (addr_ok !== 1'b1 || arvalid !== 1'b0) begin errors++; $display("FAIL single_cyc0 got addr_ok=%b arvalid=%b want 1/0", addr_ok, arvalid); end
        tick();
        req = 1'b0; addr = 32'hFFFF_FFFF;
        #1;
        checks++; if (arvalid !== 1'b1 || araddr !== 32'h1C00_0000 || arsize !== 3'b010) begin errors++; $display("FAIL single_ar got v=%b a=%h s=%b want 1/1c000000/010", arvalid, araddr, arsize); end
        tick();
        checks++; if (arvalid !== 1'b0 || rready !== 1'b1 || dut.cnt !== 3'd1) begin errors++; $display("FAIL single_post_ar got v=%b rready=%b cnt=%0d want 0/1/1", arvalid, rready, dut.cnt); end
        tick(); tick();
        rvalid = 1'b1; rdata_i = 32'h0280_0000; rresp = 2'b00;
        #1;
        checks++; if (data_ok !== 1'b0) begin errors++; $display("FAIL single_no_early_dataok got=%b want=0", data_ok); end
        tick();
        rvalid = 1'b0; rdata_i = 32'h5555_5555;
        #1;
        checks++; if (data_ok !== 1'b1 || rdata_o !== 32'h0280_0000 || err !== 1'b0) begin errors++; $display("FAIL single_data got ok=%b d=%h e=%b want 1/02800000/0", data_ok, rdata_o, err); end
        tick();
        checks++; if (data_ok !== 1'b0 || rdata_o !== 32'h0280_0000 || dut.cnt !== 3'd0) begin errors++; $display("FAIL single_pulse_end got ok=%b d=%h cnt=%0d want 0/02800000/0", data_ok, rdata_o, dut.cnt); end
    endtask

    // AR back-pressure, outstanding limit and simultaneous accept/return
    task automatic test_backpressure_and_limit();
        req = 1'b1; addr = 32'h1C00_0010; arready = 1'b0;
        #1;
        checks++; if (addr_ok !== 1'b1) begin errors++; $display("FAIL bp_accept_a got=%b want=1", addr_ok); end
        tick();
        addr = 32'h1C00_0020;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) arready = 1'b1;
            #1;
            checks++; if (arvalid !== 1'b1 || araddr !== 32'h1C00_0010 || addr_ok !== 1'b0) begin errors++; $display("FAIL bp_hold%0d got v=%b a=%h ok=%b want 1/1c000010/0", i, arvalid, araddr, addr_ok); end
            tick();
        end
        #1;
        checks++; if (arvalid !== 1'b0 || addr_ok !== 1'b1) begin errors++; $display("FAIL bp_release got v=%b ok=%b want 0/1", arvalid, addr_ok); end
        tick();
        addr = 32'h1C00_0030;
        #1;
        checks++; if (arvalid !== 1'b1 || araddr !== 32'h1C00_0020 || addr_ok !== 1'b0) begin errors++; $display("FAIL bp_second_ar got v=%b a=%h ok=%b want 1/1c000020/0", arvalid, araddr, addr_ok); end
        tick();
        #1;
        checks++; if (dut.cnt !== 3'd2 || arvalid !== 1'b0 || addr_ok !== 1'b0) begin errors++; $display("FAIL limit_block got cnt=%0d v=%b ok=%b want 2/0/0", dut.cnt, arvalid, addr_ok); end
        tick();
        rvalid = 1'b1; rdata_i = 32'h1111_0000;
        #1;
        checks++; if (addr_ok !== 1'b0) begin errors++; $display("FAIL limit_still_block got=%b want=0", addr_ok); end
        tick();
        rdata_i = 32'hAAAA_0001;
        #1;
        checks++; if (data_ok !== 1'b1 || rdata_o !== 32'h1111_0000 || dut.cnt !== 3'd1 || addr_ok !== 1'b1) begin errors++; $display("FAIL limit_reopen got ok=%b d=%h cnt=%0d aok=%b want 1/11110000/1/1", data_ok, rdata_o, dut.cnt, addr_ok); end
        tick();
        req = 1'b0; rvalid = 1'b0;
        #1;
        checks++; if (dut.cnt !== 3'd1 || data_ok !== 1'b1 || rdata_o !== 32'hAAAA_0001 || araddr !== 32'h1C00_0030) begin errors++; $display("FAIL simul got cnt=%0d ok=%b d=%h a=%h want 1/1/aaaa0001/1c000030", dut.cnt, data_ok, rdata_o, araddr); end
        tick();
        rvalid = 1'b1; rdata_i = 32'hAAAA_0002;
        #1;
        checks++; if (data_ok !== 1'b0 || arvalid !== 1'b0) begin errors++; $display("FAIL simul_gap got ok=%b v=%b want 0/0", data_ok, arvalid); end
        tick();
        rvalid = 1'b0;
        #1;
        checks++; if (data_ok !== 1'b1 || rdata_o !== 32'hAAAA_0002 || dut.cnt !== 3'd0) begin errors++; $display("FAIL order2 got ok=%b d=%h cnt=%0d want 1/aaaa0002/0", data_ok, rdata_o, dut.cnt); end
        tick();
    endtask

    task automatic test_slverr();
        req = 1'b1; addr = 32'h1C00_0100; size = 2'b01; arready = 1'b1;
        tick();
        req = 1'b0;
        #1;
        checks++; if (arsize !== 3'b001) begin errors++; $display("FAIL err_arsize got=%b want=001", arsize); end
        tick();
        rvalid = 1'b1; rdata_i = 32'hDEAD_0000; rresp = 2'b10;
        tick();
        rvalid = 1'b0; rresp = 2'b00;
        #1;
        checks++; if (data_ok !== 1'b1 || err !== 1'b1 || rdata_o !== 32'hDEAD_0000) begin errors++; $display("FAIL slverr got ok=%b e=%b d=%h want 1/1/dead0000", data_ok, err, rdata_o); end
        req = 1'b1; addr = 32'h1C00_0104; size = 2'b10;
        tick();
        req = 1'b0;
        tick();
        rvalid = 1'b1; rdata_i = 32'hBEEF_0004; rresp = 2'b00;
        tick();
        rvalid = 1'b0;
        #1;
        checks++; if (data_ok !== 1'b1 || err !== 1'b0 || rdata_o !== 32'hBEEF_0004) begin errors++; $display("FAIL okay_after_err got ok=%b e=%b d=%h want 1/0/beef0004", data_ok, err, rdata_o); end
        tick();
    endtask

    task automatic test_reset_mid();
        req = 1'b1; addr = 32'h1C00_0200; arready = 1'b1;
        tick();
        addr = 32'h1C00_0204;
        tick();
        arready = 1'b0;
        tick();
        req = 1'b0;
        #1;
        checks++; if (dut.cnt !== 3'd2 || arvalid !== 1'b1) begin errors++; $display("FAIL pre_reset got cnt=%0d v=%b want 2/1", dut.cnt, arvalid); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (arvalid !== 1'b0 || dut.cnt !== 3'd0 || rready !== 1'b0 || data_ok !== 1'b0) begin errors++; $display("FAIL mid_reset got v=%b cnt=%0d rr=%b ok=%b want 0/0/0/0", arvalid, dut.cnt, rready, data_ok); end
        tick();
        rst = 1'b0;
        tick();
        checks++; if (arvalid !== 1'b0 || dut.cnt !== 3'd0 || araddr !== 32'h0) begin errors++; $display("FAIL post_reset got v=%b cnt=%0d a=%h want 0/0/00000000", arvalid, dut.cnt, araddr); end
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_backpressure_and_limit();
        test_slverr();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
